// File: rtl/mips_pkg.sv
// mips_pkg: MIPS opcode constants shared with the main control decoder,
// loader instruction-class codes and loader FSM states.
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  typedef enum logic [1:0] {CLS_R = 2'b00, CLS_LW = 2'b01, CLS_SW = 2'b10, CLS_BEQ = 2'b11} cls_t;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} state_t;
endpackage

// File: rtl/instr_fmt.sv
// instr_fmt: packs an instruction class and its fields into a 32-bit MIPS word.
module instr_fmt import mips_pkg::*; (
  input  logic [1:0]  cls,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  output logic [31:0] word
);
  logic [5:0] op;
  always_comb begin
    op = cls == CLS_R ? OP_RTYPE : cls == CLS_LW ? OP_LW : cls == CLS_SW ? OP_SW : OP_BEQ;
    word = cls == CLS_R ? {op, rs, rt, rd, 5'b00000, funct} : {op, rs, rt, imm};
  end
endmodule

// File: rtl/instr_loader.sv
// instr_loader: accepts prog_len instruction bundles after a start request and
// writes each encoded word to consecutive instruction-memory addresses.
module instr_loader import mips_pkg::*; #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LEN_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] prog_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_class,
  input  logic [4:0]       in_rs,
  input  logic [4:0]       in_rt,
  input  logic [4:0]       in_rd,
  input  logic [5:0]       in_funct,
  input  logic [15:0]      in_imm,
  output logic             imem_we,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_wdata,
  output logic             busy,
  output logic             done
);
  state_t state;
  logic [LEN_W-1:0] idx;
  logic [LEN_W-1:0] len;
  logic [31:0] word;
  logic acc;
  assign in_ready = state == ST_LOAD;
  assign busy = state == ST_LOAD;
  assign done = state == ST_DONE;
  assign acc = in_valid && in_ready;
  instr_fmt u_fmt (
    .cls   (in_class),
    .rs    (in_rs),
    .rt    (in_rt),
    .rd    (in_rd),
    .funct (in_funct),
    .imm   (in_imm),
    .word  (word)
  );
  // The last acceptance moves to DONE so its write lands in the done cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx <= '0;
      len <= '0;
      imem_we <= 1'b0;
      imem_addr <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= acc;
      if (acc) begin
        imem_addr <= BASE_ADDR + (32'(idx) << 2);
        imem_wdata <= word;
        idx <= idx + LEN_W'(1);
      end
      case (state)
        ST_IDLE: if (start) begin
          len <= prog_len;
          idx <= '0;
          state <= prog_len == '0 ? ST_DONE : ST_LOAD;
        end
        ST_LOAD: if (acc && idx == len - LEN_W'(1)) state <= ST_DONE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: byte address of the first instruction word written.
REQ-002 Parameter LEN_W, default 8: width of the program-length and instruction-index counters.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to begin a load of prog_len instructions.
REQ-006 prog_len  in  LEN_W  number of instructions to load; sampled on the accepted start.
REQ-007 in_valid  in  1  instruction field bundle is valid.
REQ-008 in_ready  out  1  loader accepts the bundle this cycle.
REQ-009 in_class  in  2  instruction class: 00 R-type, 01 LW, 10 SW, 11 BEQ.
REQ-010 in_rs, in_rt, in_rd  in  5 each  register fields.
REQ-011 in_funct  in  6  R-type function field.
REQ-012 in_imm  in  16  immediate or offset for LW, SW and BEQ.
REQ-013 imem_we  out  1  instruction-memory write strobe.
REQ-014 imem_addr  out  32  instruction-memory byte address.
REQ-015 imem_wdata  out  32  encoded instruction word.
REQ-016 busy  out  1  high while in LOAD.
REQ-017 done  out  1  one-cycle pulse when the load completes.

Function
REQ-018 Encoding, R-type: {6'b000000, rs, rt, rd, 5'b00000, funct}.
REQ-019 Encoding, LW: {6'b100011, rs, rt, imm}.
REQ-020 Encoding, SW: {6'b101011, rs, rt, imm}.
REQ-021 Encoding, BEQ: {6'b000100, rs, rt, imm}.
REQ-022 For I-type classes, in_rd and in_funct are ignored.
REQ-023 FSM has three states: IDLE, LOAD and DONE.
REQ-024 IDLE to LOAD on start=1 with prog_len!=0; the index is cleared at this transition.
REQ-025 IDLE to DONE on start=1 with prog_len==0; no write is issued.
REQ-026 LOAD to DONE in the cycle after the prog_len-th accepted bundle.
REQ-027 DONE to IDLE unconditionally after one cycle.
REQ-028 done=1 exactly during the DONE state.
REQ-029 in_ready=1 only in LOAD; in_ready=0 in IDLE and DONE.
REQ-030 A bundle is accepted when in_valid and in_ready are both high in the same cycle.
REQ-031 A bundle accepted in cycle N produces imem_we=1 in cycle N+1 (registered, latency 1).
REQ-032 For that write, imem_wdata is the encoded word and imem_addr = BASE_ADDR + 4*index.
REQ-033 The index increments by one per accepted bundle.
REQ-034 imem_we=0 in every cycle that does not follow an acceptance.
REQ-035 Back-to-back acceptances produce back-to-back writes with no bubbles.
REQ-036 in_valid low in LOAD stalls the load: no write, index held, no timeout.
REQ-037 start while busy or in DONE is ignored, and prog_len is not resampled.
REQ-038 in_valid outside LOAD is ignored.
REQ-039 Address arithmetic is 32-bit modulo 2^32; BASE_ADDR near the top of memory wraps silently.
REQ-040 The write for the final accepted bundle occurs in the same cycle that done is high.

Reset
REQ-041 rst_n low asynchronously forces state=IDLE, index=0, stored length=0.
REQ-042 rst_n low forces outputs: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0.
REQ-043 Reset mid-load abandons the load: no further writes occur and done does not pulse.
REQ-044 The first start is honoured on the first rising edge after rst_n deasserts.

Structure
REQ-045 Shared package mips_pkg holds the opcode constants 000000/100011/101011/000100, the in_class codes and the FSM state enumeration.
REQ-046 Opcode constants are the same values the main control decoder compares against.
REQ-047 One combinational sub-module, instr_fmt (class + fields -> 32-bit word), is instantiated once.

Verification
REQ-048 Load R-type: prog_len=1, class 00, rs=1, rt=2, rd=3, funct=0x20 -> one write, addr 0x0, data 0x00221820; done on the same cycle.
REQ-049 LW/SW/BEQ streaming: prog_len=3, LW rs=0 rt=8 imm=4, SW rs=0 rt=8 imm=8, BEQ rs=1 rt=2 imm=0xFFFF, valid every cycle -> data 0x8C080004 at 0x0, 0xAC080008 at 0x4, 0x1022FFFF at 0x8 on consecutive cycles; done 3 cycles after the first accept.
REQ-050 Zero length: start with prog_len=0 -> done pulses the cycle after start; no imem_we ever.
REQ-051 Stall and ignored start: prog_len=2, in_valid low for 5 cycles between bundles, start pulsed while busy -> exactly 2 writes at 0x0 and 0x4, then one done.
REQ-052 Reset mid-load: prog_len=4, rst_n asserted after 2 accepts -> all outputs 0 immediately; no done; a fresh load after release restarts at BASE_ADDR.
REQ-053 Decoder round-trip: opcode bits [31:26] of every written word, fed to the main control decoder, give RegDst=1 for R-type, MemRead=1 for LW, MemWrite=1 for SW and Branch=1 for BEQ.
